// File: rtl/hcx_pkg.sv
// Shared encodings for the hcx stack core: opcode classes, ALU ops, jump conditions, FSM states.
package hcx_pkg;

    localparam logic [3:0] OpLdInd = 4'b1000;
    localparam logic [3:0] OpLdImm = 4'b1001;
    localparam logic [3:0] OpPop   = 4'b1010;
    localparam logic [3:0] OpJmp   = 4'b1110;
    localparam logic [7:0] OpHalt  = 8'hC0;

    typedef enum logic [2:0] {
        AluC,
        AluA,
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluNot
    } alu_op_e;

    localparam logic [2:0] JmpAlways = 3'b000;
    localparam logic [2:0] JmpNever  = 3'b001;
    localparam logic [2:0] JmpC      = 3'b010;
    localparam logic [2:0] JmpNc     = 3'b011;
    localparam logic [2:0] JmpZ      = 3'b100;
    localparam logic [2:0] JmpNz     = 3'b101;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalt
    } state_e;

endpackage

// File: rtl/hcx_alu.sv
// Combinational ALU for the hcx core; carry is only meaningful for add/sub.
module hcx_alu
    import hcx_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            AluC:   result = c;
            AluA:   result = a;
            AluAdd: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            // Carry out of a + ~b + 1 is the no-borrow flag.
            AluSub: begin
                sum    = {1'b0, a} + {1'b0, ~b} + (DATA_W + 1)'(1);
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            AluAnd: result = a & b;
            AluOr:  result = a | b;
            AluXor: result = a ^ b;
            AluNot: result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/hcx_core.sv
// Tiny stack-machine core: byte instructions fetched over a req/ack port, executed in one cycle
// against a small register stack, carry/zero flags and an internal data RAM.
module hcx_core
    import hcx_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned STACK_DEPTH = 3,
    parameter int unsigned PC_W        = 12,
    parameter int unsigned RAM_AW      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_req,
    output logic [PC_W-1:0]               imem_addr,
    input  logic                          imem_ack,
    input  logic [7:0]                    imem_rdata,
    output logic                          halted,
    output logic [PC_W-1:0]               pc_out,
    output logic [DATA_W*STACK_DEPTH-1:0] stack_out,
    output logic [1:0]                    flags_out
);

    localparam int unsigned RamDepth = 2 ** RAM_AW;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] stack_q [STACK_DEPTH];
    logic [DATA_W-1:0] stack_d [STACK_DEPTH];
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] ram [RamDepth];

    logic              ram_we;
    logic [RAM_AW-1:0] st_addr, ld_addr;
    logic [DATA_W-1:0] imm, push_data, alu_result;
    logic              alu_carry, push_en, pop_en, jmp_taken;
    alu_op_e           alu_op;

    assign alu_op  = alu_op_e'(ir_q[6:4]);
    assign st_addr = RAM_AW'(ir_q[3:0]);
    assign ld_addr = RAM_AW'({stack_q[1], stack_q[0]});
    assign imm     = DATA_W'(ir_q[3:0]);
    assign pc_inc  = pc_q + PC_W'(1);

    hcx_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (stack_q[0]),
        .b      (stack_q[1]),
        .c      (stack_q[2]),
        .op     (alu_op),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        jmp_taken = 1'b0;
        case (ir_q[2:0])
            JmpAlways: jmp_taken = 1'b1;
            JmpNever:  jmp_taken = 1'b0;
            JmpC:      jmp_taken = carry_q;
            JmpNc:     jmp_taken = !carry_q;
            JmpZ:      jmp_taken = zero_q;
            JmpNz:     jmp_taken = !zero_q;
            default:   jmp_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        ram_we    = 1'b0;
        push_en   = 1'b0;
        pop_en    = 1'b0;
        push_data = '0;
        stack_d   = stack_q;

        unique case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_inc;
                if (!ir_q[7]) begin
                    ram_we = 1'b1;
                    zero_d = (alu_result == '0);
                    if (alu_op == AluAdd || alu_op == AluSub) begin
                        carry_d = alu_carry;
                    end
                end else if (ir_q[7:4] == OpLdInd) begin
                    push_en   = 1'b1;
                    push_data = ram[ld_addr];
                end else if (ir_q[7:4] == OpLdImm) begin
                    push_en   = 1'b1;
                    push_data = imm;
                end else if (ir_q[7:4] == OpPop) begin
                    pop_en = 1'b1;
                end else if (ir_q[7:4] == OpJmp && !ir_q[3]) begin
                    if (jmp_taken) begin
                        pc_d = PC_W'({stack_q[2], stack_q[1], stack_q[0]});
                    end
                end else if (ir_q == OpHalt) begin
                    pc_d    = pc_q;
                    state_d = StHalt;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase

        if (push_en) begin
            for (int unsigned i = 1; i < STACK_DEPTH; i++) begin
                stack_d[i] = stack_q[i-1];
            end
            stack_d[0] = push_data;
        end else if (pop_en) begin
            for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) begin
                stack_d[i] = stack_q[i+1];
            end
            stack_d[STACK_DEPTH-1] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            stack_q <= stack_d;
        end
    end

    // RAM keeps its contents across reset; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram[st_addr] <= alu_result;
        end
    end

    assign imem_req  = (state_q == StFetch) && !reset;
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign halted    = (state_q == StHalt);
    assign flags_out = {carry_q, zero_q};

    for (genvar g = 0; g < STACK_DEPTH; g++) begin : g_stack_out
        assign stack_out[g*DATA_W +: DATA_W] = stack_q[g];
    end

endmodule

// File: doc/hcx_core.md
HCX_CORE -- requirements
Module: hcx_core

Interface
REQ-001 Parameter DATA_W, default 4: width of each stack level, RAM word and ALU.
REQ-002 Parameter STACK_DEPTH, default 3, legal range 3..8: number of stack levels (level 0 = A = top).
REQ-003 Parameter PC_W, default 12, legal range 4..3*DATA_W: program counter width.
REQ-004 Parameter RAM_AW, default 4, legal range 4..2*DATA_W: internal data RAM address width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  PC_W  fetch address; equals pc.
REQ-009 imem_ack  input  1  fetch data valid this cycle.
REQ-010 imem_rdata  input  8  fetched instruction byte.
REQ-011 halted  output  1  core stopped by HALT.
REQ-012 pc_out  output  PC_W  current pc.
REQ-013 stack_out  output  DATA_W*STACK_DEPTH  all levels, level 0 in LSBs.
REQ-014 flags_out  output  2  {carry, zero}.

Function
REQ-015 FSM states: FETCH, EXEC, HALT; imem_req SHALL be 1 only in FETCH with reset low.
REQ-016 FETCH: hold imem_addr stable; on imem_ack=1 latch imem_rdata into IR and go to EXEC; otherwise stay.
REQ-017 EXEC: execute IR in exactly one cycle, update pc, go to FETCH (HALT state for HALT opcode).
REQ-018 imem_ack outside FETCH SHALL be ignored; zero-wait throughput is one instruction per 2 cycles.
REQ-019 Stores 0ooo_aaaa: ram[aaaa zero-extended to RAM_AW] <= result; ooo: 000 C(level 2), 001 A, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A^B, 111 ~A.
REQ-020 Every store SHALL set zero = (result==0); only ADD/SUB SHALL update carry (ADD carry-out; SUB no-borrow, computed A+~B+1).
REQ-021 1000_xxxx LD [AB]: push ram[{B,A} truncated to RAM_AW]; 1001_iiii LD i: push iiii zero-extended to DATA_W.
REQ-022 1010_xxxx POP: each level takes the level below; bottom level becomes 0.
REQ-023 Push: level 0 <= data, level k <= level k-1; old bottom level discarded (no overflow error).
REQ-024 Loads and POP SHALL NOT change flags.
REQ-025 1110_0ccc jumps; ccc 000 JP, 001 NP, 010 JC, 011 JNC, 100 JZ, 101 JNZ, 11x NOP; taken target = {level2,level1,level0} truncated to PC_W.
REQ-026 1100_0000 HALT: pc not advanced, enter HALT, halted=1 until reset.
REQ-027 All other encodings: NOP (pc+1, no state change).
REQ-028 Non-taken/non-jump pc = pc+1 modulo 2^PC_W (wraps to 0).
REQ-029 Jump conditions use flag values prior to EXEC.

Reset
REQ-030 reset=1 at a clock edge: pc=0, all stack levels=0, carry=0, zero=0, IR=0, state=FETCH, halted=0; RAM contents not reset.
REQ-031 Reset SHALL dominate any pending fetch or EXEC in the same cycle; imem_ack during reset ignored.
REQ-032 First imem_req SHALL assert in the cycle after reset deasserts, with imem_addr=0.

Structure
REQ-033 Package hcx_pkg SHALL hold opcode class constants, ALU op codes, jump condition codes and the FSM state enum.
REQ-034 Sub-module hcx_alu (parameter DATA_W): combinational, inputs A, B, C, op; outputs result, carry.
REQ-035 RAM 2^RAM_AW x DATA_W, internal, write in EXEC only, asynchronous read.

Verification (DATA_W=4, STACK_DEPTH=3, PC_W=12, zero-wait ack unless stated)
REQ-036 LD 5, LD 3, ADD->0x2 (0x95,0x93,0x22) -> ram[2]=8, carry=0, zero=0.
REQ-037 LD 5, LD 5, SUB->0x1 -> ram[1]=0, zero=1, carry=1; then LD 0xF, LD 1, ADD->0x3 -> ram[3]=0, carry=1.
REQ-038 LD 0, LD 1, LD 2, JP (0xE0) -> next imem_addr=0x012; JC with carry=0 -> imem_addr=pc+1.
REQ-039 imem_ack held 0 for 3 cycles -> imem_req=1, imem_addr constant, instruction executed once after ack.
REQ-040 LD 1..4 (four pushes) -> stack_out=0x234; POP -> 0x023; pc=0xFFF with NOP -> 0x000.
REQ-041 HALT -> halted=1, imem_req=0 for 10 cycles, pc unchanged; reset mid-FETCH -> pc=0, stack 0, fetch restarts at 0.
